npc_seq_ctrl: RTL

- Multi-cycle sequencer for the NPC core. It steps the datapath through fetch, decode, execute, memory and writeback, and handshakes with the instruction fetch port and the data memory port.
- It latches the fetched instruction for the decoder and generates the PC and register-file write strobes.
- It halts on ebreak or on a bus timeout.
- Sits between the IFU/LSU memory interfaces and the decode/register-file/PC logic.

---
 rtl/npc_seq_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: steps FETCH/DECODE/EXEC/MEM/WB,
// handshakes with the IFU and LSU ports, and halts on ebreak or bus timeout.
module npc_seq_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [31:0] EBREAK  = 32'h00100073
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req,
  input  logic        ifu_rvalid,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_reg,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        rd_wen,
  output logic        mem_req,
  output logic        mem_wen,
  input  logic        mem_done,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halt,
  output logic        bus_err,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e        state_q;
  logic [31:0]   inst_q;
  logic [31:0]   retire_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          halt_q;
  logic          err_q;
  logic          ifu_req_q;
  logic          mem_req_q;
  logic          mem_wen_q;
  logic          pc_we_q;
  logic          rf_we_q;
  logic          store_only;
  logic          wb_rf_we;

  // Decoder inputs are stable from DECODE through WB, so they are sampled
  // on the edge entering MEM/WB to keep outputs free of input paths.
  always_comb begin
    cnt_d      = cnt_q + CW'(1);
    store_only = is_store & ~is_load;
    wb_rf_we   = rd_wen & ~store_only;
  end

  // NOTE: every register here is written with <= so all state updates see
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      retire_q  <= '0;
      cnt_q     <= '0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      ifu_req_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_wen_q <= 1'b0;
      pc_we_q   <= 1'b0;
      rf_we_q   <= 1'b0;
    end else begin
      ifu_req_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_wen_q <= 1'b0;
      pc_we_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q   <= S_FETCH;
          cnt_q     <= '0;
          ifu_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (ifu_rvalid) begin
            inst_q  <= inst_in;
            cnt_q   <= '0;
            state_q <= S_DECODE;
          end else if (cnt_d == TIMEOUT_C) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_HALT;
          end else begin
            cnt_q     <= cnt_d;
            ifu_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (inst_q == EBREAK) begin
            halt_q   <= 1'b1;
            retire_q <= retire_q + 32'd1;
            state_q  <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_q <= '0;
          if (is_load || is_store) begin
            state_q   <= S_MEM;
            mem_req_q <= 1'b1;
            mem_wen_q <= store_only;
          end else begin
            state_q <= S_WB;
            pc_we_q <= 1'b1;
            rf_we_q <= wb_rf_we;
          end
        end
        S_MEM: begin
          if (mem_done) begin
            cnt_q   <= '0;
            state_q <= S_WB;
            pc_we_q <= 1'b1;
            rf_we_q <= wb_rf_we;
          end else if (cnt_d == TIMEOUT_C) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_HALT;
          end else begin
            cnt_q     <= cnt_d;
            mem_req_q <= 1'b1;
            mem_wen_q <= store_only;
          end
        end
        S_WB: begin
          retire_q  <= retire_q + 32'd1;
          cnt_q     <= '0;
          state_q   <= S_FETCH;
          ifu_req_q <= 1'b1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          // Unused encoding: treat as a fault and park.
          err_q   <= 1'b1;
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign ifu_req    = ifu_req_q;
  assign inst_reg   = inst_q;
  assign mem_req    = mem_req_q;
  assign mem_wen    = mem_wen_q;
  assign pc_we      = pc_we_q;
  assign rf_we      = rf_we_q;
  assign halt       = halt_q;
  assign bus_err    = err_q;
  assign state      = state_q;
  assign retire_cnt = retire_q;

endmodule
